// File: rtl/axis_stim_pkg.sv
// Shared types, LFSR constants and the round-robin destination picker for axis_stim_gen.
package axis_stim_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    SEND = 3'd2,
    GAP  = 3'd3,
    DONE = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    MODE_CNT   = 2'd0,
    MODE_LFSR  = 2'd1,
    MODE_FIXED = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED = 32'hACE1_0001;

  // First set bit of mask at or after ptr, wrapping; an empty mask yields 0.
  function automatic logic [3:0] next_dest(input logic [15:0] mask, input logic [3:0] ptr);
    logic [3:0] idx;
    next_dest = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      idx = ptr + 4'(i);
      if (mask[idx]) next_dest = idx;
    end
  endfunction

endpackage

// File: rtl/axis_stim_lfsr.sv
// Galois LFSR in right-shift form; next_o is the stepped value so callers can use it
// in the same cycle the register advances.
module axis_stim_lfsr
  import axis_stim_pkg::*;
#(
  parameter int unsigned   W    = 32,
  parameter logic [W-1:0]  POLY = LFSR_POLY,
  parameter logic [W-1:0]  SEED = LFSR_SEED
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         adv,
  input  logic         reseed,
  output logic [W-1:0] state_o,
  output logic [W-1:0] next_o
);

  logic [W-1:0] lfsr_q, lfsr_d;

  assign next_o  = lfsr_q[0] ? ((lfsr_q >> 1) ^ POLY) : (lfsr_q >> 1);
  assign state_o = lfsr_q;

  always_comb begin
    lfsr_d = lfsr_q;
    if (reseed)   lfsr_d = SEED;
    else if (adv) lfsr_d = next_o;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;
  end

endmodule

// File: rtl/axis_stim_gen.sv
// AXI4-Stream stimulus generator: counter / LFSR / fixed payloads, round-robin tdest,
// programmable inter-packet gap and packet count, registered outputs with backpressure.
//
// state | meaning
// IDLE  | waiting for a rising edge on en
// LOAD  | latch packet config, pick tdest, stage beat 0
// SEND  | presenting beats until the tlast beat is accepted
// GAP   | tvalid low for gap_len cycles, then packet boundary check
// DONE  | one-cycle done pulse, sticky clr cleared
module axis_stim_gen
  import axis_stim_pkg::*;
#(
  parameter int unsigned TDATA_NUM_BYTES = 4,
  parameter int unsigned NUM_DEST        = 4,
  parameter int unsigned LEN_W           = 8,
  parameter int unsigned GAP_W           = 8,
  parameter int unsigned CNT_W           = 16,
  parameter logic [31:0] FIXED           = 32'h0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         clr,
  input  logic [1:0]                   mode_i,
  input  logic [LEN_W-1:0]             frame_len,
  input  logic [GAP_W-1:0]             gap_len,
  input  logic [CNT_W-1:0]             pkt_count,
  input  logic [NUM_DEST-1:0]          dest_mask,
  input  logic [TDATA_NUM_BYTES-1:0]   last_tkeep,
  output logic [8*TDATA_NUM_BYTES-1:0] M_AXIS_tdata,
  output logic [3:0]                   M_AXIS_tdest,
  output logic [TDATA_NUM_BYTES-1:0]   M_AXIS_tkeep,
  output logic                         M_AXIS_tlast,
  output logic                         M_AXIS_tvalid,
  input  logic                         M_AXIS_tready,
  output logic                         busy,
  output logic                         done,
  output logic [CNT_W-1:0]             seq_o
);

  localparam int unsigned DATA_W = 8 * TDATA_NUM_BYTES;
  localparam int unsigned CTR_W  = LEN_W + CNT_W;
  localparam int unsigned REP    = (DATA_W + 31) / 32;
  localparam logic [REP*32-1:0] FIXED_REP = {REP{FIXED}};

  if (DATA_W < CTR_W) begin : g_bad_width
    $fatal(1, "axis_stim_gen: DATA_W must be at least LEN_W + CNT_W");
  end
  if (NUM_DEST == 0 || NUM_DEST > 16) begin : g_bad_dest
    $fatal(1, "axis_stim_gen: NUM_DEST must be in 1..16");
  end

  state_e                     state_q, state_d;
  mode_e                      mode_q, mode_d;
  logic                       en_q;
  logic                       clr_q, clr_d;
  logic [LEN_W-1:0]           len_q, len_d;
  logic [GAP_W-1:0]           gap_q, gap_d;
  logic [TDATA_NUM_BYTES-1:0] lkeep_q, lkeep_d;
  logic [LEN_W-1:0]           beat_q, beat_d;
  logic [GAP_W-1:0]           gcnt_q, gcnt_d;
  logic [CNT_W-1:0]           seq_q, seq_d;
  logic [3:0]                 ptr_q, ptr_d;

  logic [DATA_W-1:0]          tdata_q, tdata_d;
  logic [3:0]                 tdest_q, tdest_d;
  logic [TDATA_NUM_BYTES-1:0] tkeep_q, tkeep_d;
  logic                       tlast_q, tlast_d;
  logic                       tvalid_q, tvalid_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;

  logic                       accept, run_start, load_beat;
  logic                       stop_send, stop_gap;
  logic [CNT_W-1:0]           seq_inc;
  logic [31:0]                lfsr_state, lfsr_next, lfsr_val;
  logic [REP*32-1:0]          lfsr_rep;
  logic [DATA_W-1:0]          beat_data;

  assign accept    = tvalid_q & M_AXIS_tready;
  assign run_start = (state_q == IDLE) & en & ~en_q;
  assign seq_inc   = seq_q + CNT_W'(1);
  // At the tlast acceptance seq has not yet been bumped; in GAP it already has.
  assign stop_send = ((pkt_count != '0) && (seq_inc == pkt_count)) || !en || clr_q || clr;
  assign stop_gap  = ((pkt_count != '0) && (seq_q == pkt_count)) || !en || clr_q || clr;

  axis_stim_lfsr #(
    .W    (32),
    .POLY (LFSR_POLY),
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .adv     (accept),
    .reseed  (run_start),
    .state_o (lfsr_state),
    .next_o  (lfsr_next)
  );

  // The beat staged on an acceptance must see the LFSR value it is advancing to.
  assign lfsr_val = accept ? lfsr_next : lfsr_state;
  assign lfsr_rep = {REP{lfsr_val}};

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    clr_d     = clr_q;
    len_d     = len_q;
    gap_d     = gap_q;
    lkeep_d   = lkeep_q;
    beat_d    = beat_q;
    gcnt_d    = gcnt_q;
    seq_d     = seq_q;
    ptr_d     = ptr_q;
    tdest_d   = tdest_q;
    tvalid_d  = tvalid_q;
    load_beat = 1'b0;
    if (state_q != IDLE && clr) clr_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (run_start) begin
          seq_d   = '0;
          ptr_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        len_d     = frame_len;
        gap_d     = gap_len;
        mode_d    = mode_e'(mode_i);
        lkeep_d   = last_tkeep;
        tdest_d   = next_dest(16'(dest_mask), ptr_q);
        beat_d    = '0;
        load_beat = 1'b1;
        tvalid_d  = 1'b1;
        state_d   = SEND;
      end
      SEND: begin
        if (accept) begin
          if (tlast_q) begin
            tvalid_d = 1'b0;
            seq_d    = seq_inc;
            ptr_d    = tdest_q + 4'd1;
            if (gap_q != '0) begin
              gcnt_d  = gap_q - GAP_W'(1);
              state_d = GAP;
            end else begin
              state_d = stop_send ? DONE : LOAD;
            end
          end else begin
            beat_d    = beat_q + LEN_W'(1);
            load_beat = 1'b1;
          end
        end
      end
      GAP: begin
        if (gcnt_q == '0) state_d = stop_gap ? DONE : LOAD;
        else              gcnt_d  = gcnt_q - GAP_W'(1);
      end
      DONE: begin
        clr_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (mode_d)
      MODE_LFSR:  beat_data = lfsr_rep[DATA_W-1:0];
      MODE_FIXED: beat_data = FIXED_REP[DATA_W-1:0];
      default:    beat_data = (DATA_W'(FIXED) << CTR_W) | DATA_W'({seq_q, beat_d});
    endcase
  end

  always_comb begin
    tdata_d = tdata_q;
    tkeep_d = tkeep_q;
    tlast_d = tlast_q;
    if (load_beat) begin
      tdata_d = beat_data;
      tlast_d = (beat_d == len_d);
      tkeep_d = (beat_d == len_d) ? lkeep_d : '1;
    end else if (accept) begin
      tlast_d = 1'b0;
    end
    busy_d = (state_d == LOAD) || (state_d == SEND) || (state_d == GAP);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mode_q   <= MODE_CNT;
      en_q     <= 1'b0;
      clr_q    <= 1'b0;
      len_q    <= '0;
      gap_q    <= '0;
      lkeep_q  <= '1;
      beat_q   <= '0;
      gcnt_q   <= '0;
      seq_q    <= '0;
      ptr_q    <= '0;
      tdata_q  <= '0;
      tdest_q  <= '0;
      tkeep_q  <= '1;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      en_q     <= en;
      clr_q    <= clr_d;
      len_q    <= len_d;
      gap_q    <= gap_d;
      lkeep_q  <= lkeep_d;
      beat_q   <= beat_d;
      gcnt_q   <= gcnt_d;
      seq_q    <= seq_d;
      ptr_q    <= ptr_d;
      tdata_q  <= tdata_d;
      tdest_q  <= tdest_d;
      tkeep_q  <= tkeep_d;
      tlast_q  <= tlast_d;
      tvalid_q <= tvalid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign M_AXIS_tdata  = tdata_q;
  assign M_AXIS_tdest  = tdest_q;
  assign M_AXIS_tkeep  = tkeep_q;
  assign M_AXIS_tlast  = tlast_q;
  assign M_AXIS_tvalid = tvalid_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign seq_o         = seq_q;

endmodule

// File: tb/tb_axis_stim_gen.sv
// Self-checking bench for axis_stim_gen: expected beat streams are built per run from the
// payload, destination and packet-count rules, then compared against accepted beats.
module tb_axis_stim_gen;

  localparam logic [31:0] FIXED_V   = 32'hA5C3_0F5A;
  localparam logic [31:0] SEED_V    = 32'hACE1_0001;
  localparam logic [31:0] POLY_V    = 32'h8020_0003;
  localparam int          RUN_LIMIT = 3000;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  dest;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        clr = 1'b0;
  logic [1:0]  mode_i = 2'd0;
  logic [7:0]  frame_len = 8'd0;
  logic [7:0]  gap_len = 8'd0;
  logic [15:0] pkt_count = 16'd0;
  logic [3:0]  dest_mask = 4'd0;
  logic [3:0]  last_tkeep = 4'hF;
  logic [31:0] tdata;
  logic [3:0]  tdest;
  logic [3:0]  tkeep;
  logic        tlast;
  logic        tvalid;
  logic        tready = 1'b0;
  logic        busy;
  logic        done;
  logic [15:0] seq_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axis_stim_gen #(
    .TDATA_NUM_BYTES (4),
    .NUM_DEST        (4),
    .LEN_W           (8),
    .GAP_W           (8),
    .CNT_W           (16),
    .FIXED           (FIXED_V)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .clr           (clr),
    .mode_i        (mode_i),
    .frame_len     (frame_len),
    .gap_len       (gap_len),
    .pkt_count     (pkt_count),
    .dest_mask     (dest_mask),
    .last_tkeep    (last_tkeep),
    .M_AXIS_tdata  (tdata),
    .M_AXIS_tdest  (tdest),
    .M_AXIS_tkeep  (tkeep),
    .M_AXIS_tlast  (tlast),
    .M_AXIS_tvalid (tvalid),
    .M_AXIS_tready (tready),
    .busy          (busy),
    .done          (done),
    .seq_o         (seq_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    lfsr_step = s[0] ? ((s >> 1) ^ POLY_V) : (s >> 1);
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, ".tvalid"}, 64'(tvalid), 64'(0));
    chk({tag, ".tlast"},  64'(tlast),  64'(0));
    chk({tag, ".tdata"},  64'(tdata),  64'(0));
    chk({tag, ".tdest"},  64'(tdest),  64'(0));
    chk({tag, ".tkeep"},  64'(tkeep),  64'(4'hF));
    chk({tag, ".busy"},   64'(busy),   64'(0));
    chk({tag, ".done"},   64'(done),   64'(0));
    chk({tag, ".seq"},    64'(seq_o),  64'(0));
  endtask

  // rdy: 0 always ready, 1 alternating, 2 random. stop_kind: 0 none, 1 clr pulse, 2 en drop.
  task automatic run_test(input string name, input int mode, input int len, input int gap,
                          input int cnt, input logic [3:0] mask, input logic [3:0] keep,
                          input int rdy, input int stop_kind, input int stop_beat,
                          input int exp_pkts);
    beat_t       expq[$];
    int          dl[$];
    logic [31:0] lf;
    beat_t       e, cur, prev;
    int          got, dones, post, cyc, idle;
    bit          in_gap, stall, clr_sent;
    lf = SEED_V;
    for (int i = 0; i < 4; i++) if (mask[i]) dl.push_back(i);
    for (int p = 0; p < exp_pkts; p++) begin
      for (int b = 0; b <= len; b++) begin
        case (mode)
          1:       e.data = lf;
          2:       e.data = FIXED_V;
          default: e.data = {FIXED_V[7:0], 16'(p), 8'(b)};
        endcase
        lf     = lfsr_step(lf);
        e.dest = (dl.size() == 0) ? 4'd0 : 4'(dl[p % dl.size()]);
        e.keep = (b == len) ? keep : 4'hF;
        e.last = (b == len);
        expq.push_back(e);
      end
    end
    @(negedge clk);
    mode_i     = 2'(mode);
    frame_len  = 8'(len);
    gap_len    = 8'(gap);
    pkt_count  = 16'(cnt);
    dest_mask  = mask;
    last_tkeep = keep;
    en         = 1'b0;
    clr        = 1'b0;
    tready     = 1'b1;
    @(negedge clk);
    en = 1'b1;
    got = 0; dones = 0; post = 0; cyc = 0; idle = 0;
    in_gap = 0; stall = 0; clr_sent = 0;
    prev = '0;
    while (cyc < RUN_LIMIT && !(dones > 0 && post >= 5)) begin
      @(negedge clk);
      cyc++;
      cur = {tdata, tdest, tkeep, tlast};
      if (stall) begin
        chk({name, ".hold_valid"},   64'(tvalid), 64'(1));
        chk({name, ".hold_payload"}, 64'(cur),    64'(prev));
      end
      if (tvalid) chk({name, ".busy_in_run"}, 64'(busy), 64'(1));
      if (in_gap && tvalid) begin
        chk({name, ".idle_between_pkts"}, 64'(idle), 64'(gap + 1));
        in_gap = 0;
      end else if (in_gap) begin
        idle++;
      end
      if (dones > 0) begin
        post++;
        chk({name, ".idle_after_done"}, 64'(tvalid), 64'(0));
      end
      if (done) begin
        dones++;
        chk({name, ".busy_at_done"}, 64'(busy),  64'(0));
        chk({name, ".seq_at_done"},  64'(seq_o), 64'(exp_pkts));
      end
      clr = 1'b0;
      if (stop_kind == 1 && !clr_sent && tvalid && got == stop_beat) begin
        clr      = 1'b1;
        clr_sent = 1;
      end
      if (stop_kind == 2 && tvalid && got == stop_beat) en = 1'b0;
      case (rdy)
        0:       tready = 1'b1;
        1:       tready = (cyc % 2 == 0);
        default: tready = 1'($urandom_range(1, 0));
      endcase
      if (tvalid && tready) begin
        if (got < expq.size()) begin
          chk($sformatf("%s.b%0d.data", name, got), 64'(tdata), 64'(expq[got].data));
          chk($sformatf("%s.b%0d.dest", name, got), 64'(tdest), 64'(expq[got].dest));
          chk($sformatf("%s.b%0d.keep", name, got), 64'(tkeep), 64'(expq[got].keep));
          chk($sformatf("%s.b%0d.last", name, got), 64'(tlast), 64'(expq[got].last));
        end else begin
          chk({name, ".extra_beat"}, 64'(got), 64'(expq.size()));
        end
        if (tlast) begin
          in_gap = 1;
          idle   = 0;
        end
        got++;
        stall = 0;
      end else begin
        stall = tvalid;
      end
      prev = cur;
    end
    chk({name, ".run_finished"}, 64'(dones > 0), 64'(1));
    chk({name, ".beat_count"},   64'(got),       64'(expq.size()));
    chk({name, ".done_pulses"},  64'(dones),     64'(1));
    chk({name, ".busy_end"},     64'(busy),      64'(0));
    en  = 1'b0;
    clr = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] lf;
    int          got, cyc;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_test("cnt_basic",   0, 3, 0, 2, 4'b0001, 4'hF, 0, 0, 0, 2);
    run_test("cnt_toggle",  0, 3, 0, 2, 4'b0001, 4'h7, 1, 0, 0, 2);
    run_test("cnt_random",  0, 3, 0, 2, 4'b0001, 4'h3, 2, 0, 0, 2);
    run_test("dest_rr",     0, 0, 0, 6, 4'b1011, 4'h1, 0, 0, 0, 6);
    run_test("gap5",        0, 2, 5, 3, 4'b0110, 4'hF, 0, 0, 0, 3);
    run_test("clr_abort",   0, 7, 0, 0, 4'b0001, 4'hF, 0, 1, 2, 1);
    run_test("en_drop",     0, 5, 2, 0, 4'b1111, 4'hC, 1, 2, 4, 1);
    run_test("lfsr",        1, 3, 1, 2, 4'b0101, 4'hF, 2, 0, 0, 2);
    run_test("fixed",       2, 2, 0, 2, 4'b0000, 4'h8, 0, 0, 0, 2);
    run_test("mode3",       3, 1, 0, 2, 4'b1000, 4'hF, 0, 0, 0, 2);

    // LFSR payload from the seed, then an asynchronous reset in the middle of the packet
    @(negedge clk);
    mode_i = 2'd1; frame_len = 8'd7; gap_len = 8'd0; pkt_count = 16'd0;
    dest_mask = 4'b0001; last_tkeep = 4'hF; tready = 1'b1; en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    lf = SEED_V; got = 0; cyc = 0;
    while (got < 4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (tvalid) begin
        chk($sformatf("lfsr_seed.b%0d", got), 64'(tdata), 64'(lf));
        lf = lfsr_step(lf);
        got++;
      end
    end
    chk("lfsr_seed.beats", 64'(got), 64'(4));
    @(posedge clk);
    #2;
    chk("mid_rst.valid_before", 64'(tvalid), 64'(1));
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    chk("mid_rst.tvalid", 64'(tvalid), 64'(0));
    chk("mid_rst.busy",   64'(busy),   64'(0));
    repeat (2) @(negedge clk);
    chk_reset("mid_rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      int m, l, g, c, r;
      logic [3:0] mk, kp;
      m  = $urandom_range(3, 0);
      l  = $urandom_range(7, 0);
      g  = $urandom_range(3, 0);
      c  = $urandom_range(4, 1);
      r  = $urandom_range(2, 0);
      mk = 4'($urandom_range(15, 0));
      kp = 4'($urandom_range(15, 1));
      run_test($sformatf("rnd%0d", i), m, l, g, c, mk, kp, r, 0, 0, c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
